// File: rtl/mdu_pkg.sv
// mdu_pkg: shared definitions for the iterative multiply/divide unit.
//   - mdu_op_e    : operation encodings as presented on opE
//   - mdu_state_e : sequencer states (IDLE, RUN, FIXUP)
//   - op_is_div / op_is_signed : operation decode helpers
package mdu_pkg;

  localparam int MDU_WIDTH = 32;

  typedef enum logic [1:0] {
    MDU_MULT  = 2'b00,
    MDU_MULTU = 2'b01,
    MDU_DIV   = 2'b10,
    MDU_DIVU  = 2'b11
  } mdu_op_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    FIXUP = 2'b10
  } mdu_state_e;

  // Bit 1 of the encoding selects divide; bit 0 selects unsigned.
  function automatic logic op_is_div(input logic [1:0] op);
    return op[1];
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/mdu_step.sv
// mdu_step: one iteration of the shared multiply/divide datapath (combinational).
//   partial_i [2W:0] : running state. Multiply: {acc[W:0], multiplier bits}.
//                      Divide: {remainder[W:0], remaining dividend / quotient bits}.
//   operand_i [W-1:0]: multiplicand (multiply) or divisor (divide) magnitude
//   op_i      [1:0]  : operation, only the divide/multiply selection matters here
//   partial_o [2W:0] : state after this iteration (divide: LSB left 0 for the quotient bit)
//   q_bit_o          : quotient bit produced by this iteration (0 for multiply)
module mdu_step
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic [2*WIDTH:0] partial_i,
  input  logic [WIDTH-1:0] operand_i,
  input  logic [1:0]       op_i,
  output logic [2*WIDTH:0] partial_o,
  output logic             q_bit_o
);

  logic [WIDTH:0]   upper_s;
  logic [WIDTH:0]   sum_s;
  logic [2*WIDTH:0] shifted_s;
  logic [WIDTH+1:0] diff_s;

  // Candidate results for both the shift-add and the shift-subtract step.
  always_comb begin
    upper_s   = partial_i[2*WIDTH:WIDTH];
    // The accumulator top bit is always 0 before the add, so W+1 bits never overflow.
    sum_s     = upper_s + {1'b0, operand_i};
    shifted_s = {partial_i[2*WIDTH-1:0], 1'b0};
    // Extra top bit acts as the borrow of the trial subtraction.
    diff_s    = {1'b0, shifted_s[2*WIDTH:WIDTH]} - {2'b00, operand_i};
  end

  // Select the iteration result: restoring divide keeps the difference only when no borrow.
  always_comb begin
    partial_o = {(2*WIDTH+1){1'b0}};
    q_bit_o   = 1'b0;
    if (op_is_div(op_i)) begin
      if (diff_s[WIDTH+1] == 1'b0) begin
        partial_o = {diff_s[WIDTH:0], shifted_s[WIDTH-1:0]};
        q_bit_o   = 1'b1;
      end else begin
        partial_o = shifted_s;
        q_bit_o   = 1'b0;
      end
    end else begin
      q_bit_o = 1'b0;
      if (partial_i[0]) begin
        partial_o = {1'b0, sum_s, partial_i[WIDTH-1:1]};
      end else begin
        partial_o = {1'b0, upper_s, partial_i[WIDTH-1:1]};
      end
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit for the E stage; owns HI/LO.
//   clk, reset         : clock and synchronous active-high reset
//   startE, opE        : operation request and encoding (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   srcaE, srcbE       : multiplicand/dividend and multiplier/divisor
//   stallE, flushE     : block acceptance of a new operation
//   hiwriteW, lowriteW : MTHI / MTLO commits with data wdataW
//   hi, lo             : HI / LO registers
//   mdrunE             : busy from the cycle after accept until results are written
// An operation runs WIDTH RUN cycles plus one FIXUP cycle that applies signs and
// writes HI/LO; the write-back takes priority over a simultaneous MTHI/MTLO.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = MDU_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             stallE,
  input  logic             flushE,
  input  logic             hiwriteW,
  input  logic             lowriteW,
  input  logic [WIDTH-1:0] wdataW,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             mdrunE
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  mdu_state_e       state_q, state_d;
  logic [CW-1:0]    count_q, count_d;
  logic             mdrun_q, mdrun_d;
  logic [1:0]       op_q, op_d;
  logic             neg_q, neg_d;          // operand signs differ (signed ops only)
  logic             rem_neg_q, rem_neg_d;  // dividend negative (signed ops only)
  logic             divzero_q, divzero_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [2*WIDTH:0] partial_q, partial_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  logic             accept_s;
  logic             sign_a_s, sign_b_s;
  logic [WIDTH-1:0] mag_a_s, mag_b_s;
  logic [2*WIDTH:0] step_partial_s;
  logic             step_q_bit_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0] quot_s, rem_s;
  logic [WIDTH-1:0] res_hi_s, res_lo_s;

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .partial_i (partial_q),
    .operand_i (operand_q),
    .op_i      (op_q),
    .partial_o (step_partial_s),
    .q_bit_o   (step_q_bit_s)
  );

  // Acceptance and operand magnitudes; the most-negative value maps to its unsigned magnitude.
  always_comb begin
    accept_s = startE & ~stallE & ~flushE & (state_q == IDLE);
    sign_a_s = op_is_signed(opE) & srcaE[WIDTH-1];
    sign_b_s = op_is_signed(opE) & srcbE[WIDTH-1];
    mag_a_s  = sign_a_s ? -srcaE : srcaE;
    mag_b_s  = sign_b_s ? -srcbE : srcbE;
  end

  // Sequencer: IDLE -> RUN (WIDTH iterations) -> FIXUP -> IDLE; never cancelled by stall/flush.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    mdrun_d = mdrun_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = RUN;
          count_d = {CW{1'b0}};
          mdrun_d = 1'b1;
        end else begin
          state_d = IDLE;
          mdrun_d = 1'b0;
        end
      end
      RUN: begin
        if (count_q == LAST_COUNT) begin
          state_d = FIXUP;
        end else begin
          count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      FIXUP: begin
        state_d = IDLE;
        count_d = {CW{1'b0}};
        mdrun_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        count_d = {CW{1'b0}};
        mdrun_d = 1'b0;
      end
    endcase
  end

  // Operand capture on accept and one datapath iteration per RUN cycle.
  always_comb begin
    partial_d = partial_q;
    operand_d = operand_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    divzero_d = divzero_q;
    if (accept_s) begin
      // Dividend / multiplier enters the low half; the shared step handles both ops.
      partial_d = {{(WIDTH+1){1'b0}}, mag_a_s};
      operand_d = mag_b_s;
      op_d      = opE;
      neg_d     = sign_a_s ^ sign_b_s;
      rem_neg_d = sign_a_s;
      divzero_d = (srcbE == {WIDTH{1'b0}});
    end else if (state_q == RUN) begin
      // Step leaves LSB 0 on divide for the quotient bit; q_bit is 0 on multiply.
      partial_d = {step_partial_s[2*WIDTH:1], step_partial_s[0] | step_q_bit_s};
    end else begin
      partial_d = partial_q;
    end
  end

  // Sign correction of the finished magnitude result.
  always_comb begin
    prod_s   = partial_q[2*WIDTH-1:0];
    quot_s   = partial_q[WIDTH-1:0];
    rem_s    = partial_q[2*WIDTH-1:WIDTH];
    res_hi_s = {WIDTH{1'b0}};
    res_lo_s = {WIDTH{1'b0}};
    if (op_is_div(op_q)) begin
      if (divzero_q) begin
        res_lo_s = {WIDTH{1'b1}};
      end else begin
        res_lo_s = neg_q ? -quot_s : quot_s;
      end
      res_hi_s = rem_neg_q ? -rem_s : rem_s;
    end else begin
      if (neg_q) begin
        prod_s = -partial_q[2*WIDTH-1:0];
      end else begin
        prod_s = partial_q[2*WIDTH-1:0];
      end
      res_hi_s = prod_s[2*WIDTH-1:WIDTH];
      res_lo_s = prod_s[WIDTH-1:0];
    end
  end

  // HI/LO update: FIXUP write-back wins over a coincident MTHI/MTLO.
  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (state_q == FIXUP) begin
      hi_d = res_hi_s;
      lo_d = res_lo_s;
    end else begin
      if (hiwriteW) begin
        hi_d = wdataW;
      end else begin
        hi_d = hi_q;
      end
      if (lowriteW) begin
        lo_d = wdataW;
      end else begin
        lo_d = lo_q;
      end
    end
  end

  // State registers with synchronous reset; reset aborts any running operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= {CW{1'b0}};
      mdrun_q   <= 1'b0;
      op_q      <= 2'b00;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      divzero_q <= 1'b0;
      operand_q <= {WIDTH{1'b0}};
      partial_q <= {(2*WIDTH+1){1'b0}};
      hi_q      <= {WIDTH{1'b0}};
      lo_q      <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      mdrun_q   <= mdrun_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      divzero_q <= divzero_d;
      operand_q <= operand_d;
      partial_q <= partial_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign hi     = hi_q;
  assign lo     = lo_q;
  assign mdrunE = mdrun_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: stimulus pushes expected HI/LO computed with
// plain 64-bit arithmetic; a negedge monitor pops and compares on each busy->idle fall.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk;
  logic         reset;
  logic         startE;
  logic [1:0]   opE;
  logic [W-1:0] srcaE, srcbE;
  logic         stallE, flushE;
  logic         hiwriteW, lowriteW;
  logic [W-1:0] wdataW;
  logic [W-1:0] hi, lo;
  logic         mdrunE;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
  } exp_t;

  exp_t         exp_q[$];
  int           n_checks = 0;
  int           n_fail   = 0;
  bit           abort_run = 1'b0;
  bit           prev_run  = 1'b0;
  int           run_len   = 0;
  logic [W-1:0] model_hi = '0;
  logic [W-1:0] model_lo = '0;

  mult_div_unit #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .startE   (startE),
    .opE      (opE),
    .srcaE    (srcaE),
    .srcbE    (srcbE),
    .stallE   (stallE),
    .flushE   (flushE),
    .hiwriteW (hiwriteW),
    .lowriteW (lowriteW),
    .wdataW   (wdataW),
    .hi       (hi),
    .lo       (lo),
    .mdrunE   (mdrunE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b required %b", name, act, req);
    end
  endtask

  // Reference: MIPS HI/LO semantics from 64-bit host arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t r;
    longint sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p, q, m;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r.hi = '0;
    r.lo = '0;
    case (op)
      2'b00: begin p = sa * sb; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b01: begin p = ua * ub; r.hi = p[63:32]; r.lo = p[31:0]; end
      2'b10: begin
        if (b == '0) begin r.lo = '1; r.hi = a; end
        else begin q = sa / sb; m = sa % sb; r.lo = q[31:0]; r.hi = m[31:0]; end
      end
      default: begin
        if (b == '0) begin r.lo = '1; r.hi = a; end
        else begin q = ua / ub; m = ua % ub; r.lo = q[31:0]; r.hi = m[31:0]; end
      end
    endcase
    return r;
  endfunction

  // Monitor: every busy->idle transition presents a result (unless reset aborted it).
  always @(negedge clk) begin
    exp_t e;
    if (mdrunE) begin
      run_len++;
    end else if (prev_run) begin
      if (abort_run) begin
        abort_run = 1'b0;
      end else if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got hi=%h lo=%h required no result", hi, lo);
      end else begin
        e = exp_q.pop_front();
        check("result_hi", hi, e.hi);
        check("result_lo", lo, e.lo);
        check("busy_cycles", 32'(run_len), 32'(W + 1));
      end
      run_len = 0;
    end
    prev_run = mdrunE;
  end

  // A start request must never be presented while the unit is busy.
  always @(posedge clk) begin
    if (startE && mdrunE) begin
      n_checks++;
      n_fail++;
      $display("FAIL start_while_busy: got startE=1 with mdrunE=1 required startE=0");
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100 && mdrunE; i++) @(negedge clk);
    if (mdrunE) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got mdrunE=1 required 0 within 100 cycles");
    end
  endtask

  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int stall_n, input bit collide);
    exp_t e;
    e = model(op, a, b);
    exp_q.push_back(e);
    model_hi = e.hi;
    model_lo = e.lo;
    @(negedge clk);
    startE = 1'b1; opE = op; srcaE = a; srcbE = b;
    stallE = (stall_n > 0);
    for (int i = 0; i < stall_n; i++) begin
      @(negedge clk);
      check_bit("stall_no_accept", mdrunE, 1'b0);
    end
    stallE = 1'b0;
    @(negedge clk);
    startE = 1'b0;
    check_bit("busy_rise", mdrunE, 1'b1);
    if (collide) begin
      repeat (W) @(negedge clk);
      lowriteW = 1'b1;
      wdataW   = 32'hDEAD_BEEF;
      @(negedge clk);
      lowriteW = 1'b0;
    end
    wait_idle();
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    n_fail++;
    $display("FAIL watchdog: got no completion required finish within time limit");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    reset = 1'b1; startE = 1'b0; opE = 2'b00; srcaE = '0; srcbE = '0;
    stallE = 1'b0; flushE = 1'b0; hiwriteW = 1'b0; lowriteW = 1'b0; wdataW = '0;
    repeat (2) @(negedge clk);
    check("reset_hi", hi, 32'h0);
    check("reset_lo", lo, 32'h0);
    check_bit("reset_busy", mdrunE, 1'b0);
    reset = 1'b0;

    // Directed cases
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'b00, 32'hFFFF_FFF9, 32'h0000_0003, 0, 1'b0);
    run_op(2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 0, 1'b0);
    run_op(2'b11, 32'd100, 32'h0, 0, 1'b0);
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(2'b01, 32'd12345, 32'd678, 3, 1'b0);

    // Flushed start is not accepted and leaves HI/LO alone
    @(negedge clk);
    startE = 1'b1; flushE = 1'b1; opE = 2'b01; srcaE = 32'd9; srcbE = 32'd9;
    @(negedge clk);
    startE = 1'b0; flushE = 1'b0;
    check_bit("flush_no_accept", mdrunE, 1'b0);
    @(negedge clk);
    check_bit("flush_still_idle", mdrunE, 1'b0);
    check("flush_hi", hi, model_hi);
    check("flush_lo", lo, model_lo);

    // MTHI then MTLO while idle
    hiwriteW = 1'b1; wdataW = 32'h0000_1234;
    @(negedge clk);
    hiwriteW = 1'b0;
    model_hi = 32'h0000_1234;
    check("mthi_hi", hi, model_hi);
    check("mthi_lo", lo, model_lo);
    lowriteW = 1'b1; wdataW = 32'h0000_5678;
    @(negedge clk);
    lowriteW = 1'b0;
    model_lo = 32'h0000_5678;
    check("mtlo_lo", lo, model_lo);
    check("mtlo_hi", hi, model_hi);

    // MTLO colliding with the write-back
    run_op(2'b10, 32'd1000, 32'd7, 0, 1'b1);

    // Reset in the middle of RUN (count = 10)
    @(negedge clk);
    startE = 1'b1; opE = 2'b01; srcaE = 32'd77; srcbE = 32'd55;
    @(negedge clk);
    startE = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    abort_run = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_hi = '0;
    model_lo = '0;
    check_bit("abort_busy", mdrunE, 1'b0);
    check("abort_hi", hi, 32'h0);
    check("abort_lo", lo, 32'h0);
    run_op(2'b01, 32'd2, 32'd3, 0, 1'b0);

    // Randomized operations
    for (int i = 0; i < 30; i++) begin
      logic [1:0]   op;
      logic [W-1:0] a, b;
      op = 2'($urandom_range(0, 3));
      a  = pick();
      b  = pick();
      run_op(op, a, b, 0, 1'b0);
    end

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pending_results: got %0d outstanding required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
